// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic valid/ready pipeline stage register with optional 2-entry skid
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             bubble,
    output logic [1:0]       occupancy
);

    // Occupancy doubles as the state encoding so the count is exact at every edge.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } skid_state_t;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    generate
        if (SKID == 0) begin : g_single
            logic             valid_q;
            logic [WIDTH-1:0] data_q;

            // The stall path runs straight through: downstream ready frees the slot in the same cycle.
            assign in_ready  = rst_n & ~bubble & (~valid_q | out_ready);
            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign occupancy = {1'b0, valid_q};

            // Single holding register; flush wins over any transfer and parks the payload at RESET_VAL.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= RESET_VAL;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    data_q  <= RESET_VAL;
                end else if (in_xfer) begin
                    valid_q <= 1'b1;
                    data_q  <= in_data;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                end
            end
        end else begin : g_skid
            skid_state_t      state_q;
            skid_state_t      state_d;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             in_ready_q;
            logic             out_valid_q;

            // Main register always feeds the output; skid only catches the overflow beat.
            assign in_ready  = in_ready_q;
            assign out_valid = out_valid_q;
            assign out_data  = main_q;
            assign occupancy = state_q;

            // Next fill level from this cycle's transfers; flush empties the stage outright.
            always_comb begin
                state_d = state_q;
                if (flush) begin
                    state_d = S_EMPTY;
                end else begin
                    case (state_q)
                        S_EMPTY: if (in_xfer) state_d = S_ONE;
                        S_ONE: begin
                            if (in_xfer && !out_xfer)      state_d = S_FULL;
                            else if (!in_xfer && out_xfer) state_d = S_EMPTY;
                        end
                        S_FULL:  if (out_xfer) state_d = S_ONE;
                        default: state_d = S_EMPTY;
                    endcase
                end
            end

            // State, data movement and the registered handshake outputs; main stays put while stalled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q     <= S_EMPTY;
                    main_q      <= RESET_VAL;
                    skid_q      <= RESET_VAL;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end else begin
                    state_q     <= state_d;
                    in_ready_q  <= (state_d != S_FULL) && !bubble;
                    out_valid_q <= (state_d != S_EMPTY);
                    if (flush) begin
                        main_q <= RESET_VAL;
                    end else begin
                        case (state_q)
                            S_EMPTY: if (in_xfer) main_q <= in_data;
                            S_ONE: begin
                                if (in_xfer && out_xfer) main_q <= in_data;
                                else if (in_xfer)        skid_q <= in_data;
                            end
                            S_FULL:  if (out_xfer) main_q <= skid_q;
                            default: main_q <= main_q;
                        endcase
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and randomized checks of pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int NR = 5;
    localparam int MW = 200;
    localparam logic [31:0] D_RST = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic int cfg_w(int g);
        case (g)
            0: return 1;
            1: return 32;
            2: return 1;
            3: return 32;
            default: return 200;
        endcase
    endfunction

    function automatic int cfg_skid(int g);
        return (g < 2) ? 0 : 1;
    endfunction

    function automatic logic [MW-1:0] mask_of(int g);
        logic [MW-1:0] m = '0;
        for (int i = 0; i < cfg_w(g); i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_word();
        logic [MW-1:0] v = '0;
        for (int i = 0; i < 7; i++) v = {v[MW-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed instance
    logic        d_iv, d_ir, d_ov, d_or, d_fl, d_bb;
    logic [31:0] d_id, d_od;
    logic [1:0]  d_occ;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .RESET_VAL(D_RST)) u_dir (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
        .out_valid(d_ov), .out_ready(d_or), .out_data(d_od),
        .flush(d_fl), .bubble(d_bb), .occupancy(d_occ)
    );

    // Randomized instances
    logic          r_iv [NR];
    logic          r_ir [NR];
    logic          r_ov [NR];
    logic          r_or [NR];
    logic          r_fl [NR];
    logic          r_bb [NR];
    logic [MW-1:0] r_id [NR];
    logic [MW-1:0] r_od [NR];
    logic [1:0]    r_occ[NR];

    generate
        for (genvar g = 0; g < NR; g++) begin : g_rand
            localparam int W  = cfg_w(g);
            localparam int SK = cfg_skid(g);
            logic [W-1:0] id_loc;
            logic [W-1:0] od_loc;
            logic         ir_loc;
            logic         ov_loc;
            logic [1:0]   occ_loc;

            assign id_loc   = r_id[g][W-1:0];
            assign r_ir[g]  = ir_loc;
            assign r_ov[g]  = ov_loc;
            assign r_occ[g] = occ_loc;
            assign r_od[g]  = MW'(od_loc);

            pipe_stage_reg #(.WIDTH(W), .SKID(SK)) u_dut (
                .clk(clk), .rst_n(rst_n),
                .in_valid(r_iv[g]), .in_ready(ir_loc), .in_data(id_loc),
                .out_valid(ov_loc), .out_ready(r_or[g]), .out_data(od_loc),
                .flush(r_fl[g]), .bubble(r_bb[g]), .occupancy(occ_loc)
            );
        end
    endgenerate

    // Reference model state: beats held, in arrival order
    logic [MW-1:0] mq [NR][$];
    logic          prev_bb [NR];
    logic          last_in_x [NR];
    logic          prev_stall [NR];
    logic [MW-1:0] prev_od [NR];

    initial begin
        int sent, got, gaps, deferred;
        logic exp_ir, in_x, out_x;
        logic [MW-1:0] m;

        rst_n = 1'b0;
        d_iv = 0; d_or = 0; d_fl = 0; d_bb = 0; d_id = '0;
        for (int g = 0; g < NR; g++) begin
            r_iv[g] = 0; r_or[g] = 0; r_fl[g] = 0; r_bb[g] = 0; r_id[g] = '0;
            prev_bb[g] = 0; last_in_x[g] = 0; prev_stall[g] = 0; prev_od[g] = '0;
        end

        // Reset
        repeat (3) @(negedge clk);
        check("rst_in_ready", d_ir, 0);
        check("rst_out_valid", d_ov, 0);
        check("rst_out_data", d_od, D_RST);
        check("rst_occ", d_occ, 0);
        check("rst_s0_in_ready", r_ir[1], 0);
        rst_n = 1'b1;
        #1;
        check("rel_s0_in_ready", r_ir[1], 1);
        @(negedge clk);
        check("rel_in_ready", d_ir, 1);
        check("rel_out_valid", d_ov, 0);
        check("rel_out_data", d_od, D_RST);
        check("rel_occ", d_occ, 0);

        // Back-to-back stream
        d_or = 1;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0) begin
                check("stream_valid", d_ov, 1);
                check("stream_data", d_od, 32'h100 + 32'(i - 1));
            end
            if (i < 16) begin
                check("stream_in_ready", d_ir, 1);
                d_iv = 1; d_id = 32'h100 + 32'(i);
            end else begin
                d_iv = 0;
            end
        end
        @(negedge clk);
        check("stream_drained", d_ov, 0);

        // Stall into the skid
        d_or = 0; d_iv = 1; d_id = 32'hA;
        @(negedge clk);
        check("stall_occ1", d_occ, 1);
        check("stall_ready1", d_ir, 1);
        d_id = 32'hB;
        @(negedge clk);
        check("stall_occ2", d_occ, 2);
        check("stall_ready2", d_ir, 0);
        d_id = 32'hC;
        @(negedge clk);
        check("stall_occ3", d_occ, 2);
        check("stall_ready3", d_ir, 0);
        check("stall_hold_a", d_od, 32'hA);
        d_or = 1;
        @(negedge clk);
        check("rel_data_b", d_od, 32'hB);
        check("rel_occ_b", d_occ, 1);
        check("rel_ready_b", d_ir, 1);
        @(negedge clk);
        check("rel_data_c", d_od, 32'hC);
        check("rel_valid_c", d_ov, 1);
        d_iv = 0;
        @(negedge clk);
        check("rel_empty", d_occ, 0);
        check("rel_empty_valid", d_ov, 0);

        // Flush while full with an incoming beat
        d_or = 0; d_iv = 1; d_id = 32'h11;
        @(negedge clk);
        d_id = 32'h22;
        @(negedge clk);
        check("flush_pre_occ", d_occ, 2);
        d_fl = 1; d_id = 32'h33;
        @(negedge clk);
        d_fl = 0; d_iv = 0;
        check("flush_valid", d_ov, 0);
        check("flush_occ", d_occ, 0);
        check("flush_data", d_od, D_RST);
        check("flush_ready", d_ir, 1);
        d_or = 1;
        repeat (3) begin
            @(negedge clk);
            check("flush_no_33", d_ov, 0);
        end

        // One-cycle bubble while streaming
        sent = 0; got = 0; gaps = 0; deferred = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_ov) begin
                check("bubble_data", d_od, 32'h200 + 32'(got));
                got++;
            end else if (got > 0 && got < 8) begin
                gaps++;
            end
            d_iv = (sent < 8);
            d_id = 32'h200 + 32'(sent);
            d_bb = (c == 3);
            #1;
            if (d_iv && !d_ir) deferred++;
            if (d_iv && d_ir) sent++;
        end
        d_iv = 0; d_bb = 0;
        check("bubble_got", 32'(got), 8);
        check("bubble_gaps", 32'(gaps), 1);
        check("bubble_deferred", 32'(deferred), 1);

        // Randomized traffic against a queue scoreboard
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < NR; g++) begin
                m = mask_of(g);
                check("rnd_occ", MW'(r_occ[g]), MW'(mq[g].size()));
                check("rnd_valid", MW'(r_ov[g]), MW'(mq[g].size() != 0));
                if (mq[g].size() != 0) check("rnd_data", r_od[g] & m, mq[g][0] & m);
                if (prev_stall[g]) check("rnd_stable", r_od[g] & m, prev_od[g] & m);
                prev_od[g] = r_od[g];
                if (!(r_iv[g] && !last_in_x[g] && !r_fl[g])) begin
                    r_iv[g] = ($urandom_range(0, 9) < 7);
                    r_id[g] = rand_word() & m;
                end
                r_or[g] = ($urandom_range(0, 9) < 6);
                r_fl[g] = ($urandom_range(0, 99) < 3);
                r_bb[g] = ($urandom_range(0, 9) == 0);
            end
            #1;
            for (int g = 0; g < NR; g++) begin
                if (cfg_skid(g) == 0) exp_ir = !r_bb[g] && (mq[g].size() == 0 || r_or[g]);
                else                  exp_ir = (mq[g].size() < 2) && !prev_bb[g];
                check("rnd_in_ready", MW'(r_ir[g]), MW'(exp_ir));
                in_x  = r_iv[g] && exp_ir;
                out_x = (mq[g].size() != 0) && r_or[g];
                prev_stall[g] = (mq[g].size() != 0) && !r_or[g] && !r_fl[g];
                if (out_x) void'(mq[g].pop_front());
                if (r_fl[g]) mq[g].delete();
                else if (in_x) mq[g].push_back(r_id[g]);
                last_in_x[g] = in_x;
                prev_bb[g]   = r_bb[g];
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
